pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipelined RV64 CPU. Each cycle it decides whether every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds or is cleared to a bubble. It covers three hazard sources:
- load-use data hazards detected between ID and EX;
- control redirects resolved in MEM;
- multi-cycle data-memory accesses through a req/ready handshake.

It also keeps saturating performance counters for stalls and flushes.

---
 rtl/pipeline_hazard_ctrl_if.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Data-memory request/ready handshake between the hazard controller and
//   the data memory.
//   dmem_req    controller -> memory  an access is outstanding this cycle
//   dmem_ready  memory -> controller  the outstanding access completes now
//   Modports: master = hazard controller, slave = data memory.

interface pipeline_hazard_ctrl_if;
  logic dmem_req;
  logic dmem_ready;

  modport master (output dmem_req, input dmem_ready);
  modport slave  (input dmem_req, output dmem_ready);
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage RV64 pipeline. Each cycle
//   it decides whether each pipeline register loads, holds or is cleared to a
//   bubble. Hazard sources: load-use (ID vs EX), control redirects resolved
//   in MEM, and multi-cycle data-memory accesses. Also keeps saturating
//   stall/flush performance counters.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs*   ID-stage source registers and their use flags
//   ex_rd, ex_MemRead           destination and load flag of the EX instruction
//   mem_MemRead/mem_MemWrite    MEM instruction accesses data memory
//   mem_redirect                MEM-stage branch taken / jump
//   dmem (master)               dmem_req / dmem_ready handshake
//   *_en                        pipeline register load enables (0 = hold)
//   *_flush                     synchronous clear-to-bubble requests
//   mem_busy, mem_error         waiting on memory / sticky timeout flag
//   stall_cnt, flush_cnt        saturating event counters

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_MemRead,
  input  logic                 mem_MemRead,
  input  logic                 mem_MemWrite,
  input  logic                 mem_redirect,
  pipeline_hazard_ctrl_if.master dmem,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
  output logic                 mem_busy,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last MEM_WAIT cycle index before the access is abandoned.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              mem_acc;
  logic              load_use;
  logic              mem_stall;
  logic              timeout;
  logic              req;
  logic              redirect_take;

  assign mem_acc  = mem_MemRead | mem_MemWrite;
  assign mem_busy = (state == MEM_WAIT);

  // x0 is never a real dependency, and an unread source cannot create one.
  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // Memory FSM: the IDLE cycle that discovers a not-ready access already
  // stalls, so an N-cycle access costs N-1 stall cycles. The ready or
  // timeout cycle itself lets the pipeline advance.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    mem_stall  = 1'b0;
    timeout    = 1'b0;
    req        = 1'b0;
    case (state)
      IDLE: begin
        req = mem_acc;
        if (mem_acc && !dmem.dmem_ready) begin
          mem_stall  = 1'b1;
          state_next = MEM_WAIT;
          wait_next  = '0;
        end
      end
      MEM_WAIT: begin
        req       = 1'b1;
        wait_next = wait_cnt + 1'b1;
        if (dmem.dmem_ready) begin
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pipeline control with priority memory wait > redirect > load-use.
  // A timed-out access still flushes MEM/WB so it never writes back.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    redirect_take = 1'b0;
    dmem.dmem_req = req;
    if (reset) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
      mem_wb_flush  = 1'b1;
      dmem.dmem_req = 1'b0;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else begin
      mem_wb_flush = timeout;
      if (mem_redirect) begin
        redirect_take = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_error <= 1'b0;
    end else if (timeout) begin
      mem_error <= 1'b1;
    end
  end

  // Saturating performance counters (an all-ones value stops counting).
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect_take && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Self-checking bench for pipeline_hazard_ctrl. A behavioural model that
//   tracks the age of the outstanding memory access and plain event counts
//   predicts every output each cycle; directed scenarios add literal checks.
//   Ports: none (top-level bench).

module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_MemRead, mem_MemRead, mem_MemWrite, mem_redirect;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic             mem_busy, mem_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead),
    .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .mem_redirect(mem_redirect),
    .dmem(bus),
    .pc_en(pc_en),
    .if_id_en(if_id_en),
    .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush),
    .mem_busy(mem_busy),
    .mem_error(mem_error),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Model state: age of the outstanding access in cycles, sticky error, counts.
  int m_age    = 0;
  bit m_err    = 1'b0;
  int m_stalls = 0;
  int m_flushes = 0;

  bit m_acc, m_outstanding, m_mstall, m_tout, m_lu, m_redir;
  bit e_pc, e_ifid, e_idex, e_exmem;
  bit f_ifid, f_idex, f_exmem, f_memwb, e_req;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input bit rst, input bit [4:0] rs1, input bit u1,
                               input bit [4:0] rs2, input bit u2, input bit [4:0] rd,
                               input bit ld, input bit mrd, input bit mwr,
                               input bit redir, input bit rdy);
    @(posedge clk);
    #1;
    reset        = rst;
    id_rs1       = rs1;
    id_use_rs1   = u1;
    id_rs2       = rs2;
    id_use_rs2   = u2;
    ex_rd        = rd;
    ex_MemRead   = ld;
    mem_MemRead  = mrd;
    mem_MemWrite = mwr;
    mem_redirect = redir;
    bus.dmem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Model and per-cycle compare.
  always @(negedge clk) begin
    if (checking) begin
      m_acc = mem_MemRead || mem_MemWrite;
      m_outstanding = (m_age > 0) || m_acc;
      m_mstall = 1'b0;
      m_tout   = 1'b0;
      if (!reset && m_outstanding && !bus.dmem_ready) begin
        if (m_age == MEM_TIMEOUT) m_tout = 1'b1;
        else m_mstall = 1'b1;
      end
      m_lu = ex_MemRead && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      m_redir = !reset && !m_mstall && mem_redirect;

      e_req   = !reset && m_outstanding;
      e_pc    = reset || (!m_mstall && (m_redir || !m_lu));
      e_ifid  = e_pc;
      e_idex  = reset || !m_mstall;
      e_exmem = e_idex;
      f_ifid  = reset || m_redir;
      f_idex  = reset || m_redir || (!m_mstall && m_lu);
      f_exmem = reset || m_redir;
      f_memwb = reset || m_mstall || m_tout;

      checkOutput("pc_en", pc_en, e_pc);
      checkOutput("if_id_en", if_id_en, e_ifid);
      checkOutput("id_ex_en", id_ex_en, e_idex);
      checkOutput("ex_mem_en", ex_mem_en, e_exmem);
      checkOutput("if_id_flush", if_id_flush, f_ifid);
      checkOutput("id_ex_flush", id_ex_flush, f_idex);
      checkOutput("ex_mem_flush", ex_mem_flush, f_exmem);
      checkOutput("mem_wb_flush", mem_wb_flush, f_memwb);
      checkOutput("dmem_req", bus.dmem_req, e_req);
      checkOutput("mem_busy", mem_busy, m_age > 0);
      checkOutput("mem_error", mem_error, m_err);
      checkOutput("stall_cnt", stall_cnt, m_stalls);
      checkOutput("flush_cnt", flush_cnt, m_flushes);

      // Advance the model to what holds after the coming rising edge.
      if (reset) begin
        m_age = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
      end else begin
        if (!e_pc && m_stalls < CNT_MAX) m_stalls++;
        if (m_redir && m_flushes < CNT_MAX) m_flushes++;
        if (m_tout) m_err = 1'b1;
        m_age = m_mstall ? m_age + 1 : 0;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_MemRead = 0; mem_MemRead = 0; mem_MemWrite = 0; mem_redirect = 0;
    bus.dmem_ready = 0;
    checking = 1'b1;

    // Reset held: everything flushes, no memory request even with an access.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("rst_pc_en", pc_en, 1);
    checkOutput("rst_id_ex_flush", id_ex_flush, 1);
    checkOutput("rst_mem_wb_flush", mem_wb_flush, 1);
    checkOutput("rst_dmem_req", bus.dmem_req, 0);
    idleCycle();
    checkOutput("init_stall_cnt", stall_cnt, 0);
    checkOutput("init_mem_busy", mem_busy, 0);
    checkOutput("init_if_id_flush", if_id_flush, 0);

    // Load-use on rs1: one bubble.
    applyStimulus(0, 5, 1, 0, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("lu_pc_en", pc_en, 0);
    checkOutput("lu_if_id_en", if_id_en, 0);
    checkOutput("lu_id_ex_flush", id_ex_flush, 1);
    checkOutput("lu_ex_mem_en", ex_mem_en, 1);
    idleCycle();
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    // x0 destination and an unused matching rs2 do not stall; a used one does.
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("x0_pc_en", pc_en, 1);
    applyStimulus(0, 3, 1, 7, 0, 7, 1, 0, 0, 0, 0);
    checkOutput("unused_rs2_pc_en", pc_en, 1);
    applyStimulus(0, 3, 1, 7, 1, 7, 1, 0, 0, 0, 0);
    checkOutput("rs2_lu_pc_en", pc_en, 0);

    // Redirect wins over load-use.
    applyStimulus(0, 5, 1, 0, 0, 5, 1, 0, 0, 1, 0);
    checkOutput("redir_if_id_flush", if_id_flush, 1);
    checkOutput("redir_ex_mem_flush", ex_mem_flush, 1);
    checkOutput("redir_pc_en", pc_en, 1);
    idleCycle();
    checkOutput("redir_flush_cnt", flush_cnt, 1);
    checkOutput("redir_stall_cnt", stall_cnt, 2);

    // 3-cycle load; redirect during the wait is ignored.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("ld3_c1_req", bus.dmem_req, 1);
    checkOutput("ld3_c1_pc_en", pc_en, 0);
    checkOutput("ld3_c1_busy", mem_busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("ld3_c2_busy", mem_busy, 1);
    checkOutput("ld3_c2_if_id_flush", if_id_flush, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    checkOutput("ld3_c3_pc_en", pc_en, 1);
    checkOutput("ld3_c3_req", bus.dmem_req, 1);
    checkOutput("ld3_c3_mem_wb_flush", mem_wb_flush, 0);
    idleCycle();
    checkOutput("ld3_stall_cnt", stall_cnt, 4);
    checkOutput("ld3_flush_cnt", flush_cnt, 1);

    // Single-cycle write, and ready with no access.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("wr1_pc_en", pc_en, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("stray_ready_req", bus.dmem_req, 0);

    // Redirect held through a wait takes effect on the ready cycle.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    checkOutput("late_redir_flush", if_id_flush, 1);
    idleCycle();
    checkOutput("late_redir_flush_cnt", flush_cnt, 2);

    // Timeout after MEM_TIMEOUT wait cycles; error is sticky.
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("to_pc_en", pc_en, 1);
    checkOutput("to_mem_wb_flush", mem_wb_flush, 1);
    checkOutput("to_err_before", mem_error, 0);
    idleCycle();
    checkOutput("to_mem_error", mem_error, 1);
    checkOutput("to_busy", mem_busy, 0);
    checkOutput("to_stall_cnt", stall_cnt, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idleCycle();
    checkOutput("to_sticky", mem_error, 1);

    // Reset in the middle of a wait.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("rstw_req", bus.dmem_req, 0);
    idleCycle();
    checkOutput("rstw_busy", mem_busy, 0);
    checkOutput("rstw_stall_cnt", stall_cnt, 0);
    checkOutput("rstw_flush_cnt", flush_cnt, 0);
    checkOutput("rstw_mem_error", mem_error, 0);

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 9, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    end
    idleCycle();
    checkOutput("sat_stall_cnt", stall_cnt, CNT_MAX);
    checkOutput("sat_flush_cnt", flush_cnt, CNT_MAX);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
